// File: rtl/ysyx_25030093_lsu_pkg.sv
// Shared definitions for the ysyx_25030093 load/store unit.
//   - funct3 memory-op encodings (LSU_LB .. LSU_LHU)
//   - LSU controller state enum
//   - AXI response code RESP_OKAY
//   - is_misaligned(): alignment rule used by the optional trap
//     (LSU_MISALIGN_TRAP_EN)
package ysyx_25030093_lsu_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_AR,
    ST_RD_R,
    ST_WR_AW_W,
    ST_WR_B,
    ST_DONE
  } state_e;

  // Bytes never misalign; halfwords need addr[0]=0; words and the
  // illegal encodings (which behave as words) need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
    case (op)
      LSU_LB, LSU_LBU: return 1'b0;
      LSU_LH, LSU_LHU: return addr_lo[0];
      default:         return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_if.sv
// Bus bundle around the LSU: EXU request/response channel plus the
// AXI-lite master channels (AR/R, AW/W/B) towards the SRAM slave.
//   modport master : the LSU side (drives AXI requests and EXU responses)
//   modport slave  : the environment side (EXU + memory slave)
interface ysyx_25030093_lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // EXU request / WBU response
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  // AXI-lite read
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;
  // AXI-lite write
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic              awready;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wready;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (
    input  req_valid, req_wen, req_op, req_addr, req_wdata,
           arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    output req_ready, resp_valid, resp_rdata, resp_err,
           arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );

  modport slave (
    output req_valid, req_wen, req_op, req_addr, req_wdata,
           arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready
  );

endinterface

// File: rtl/ysyx_25030093_lsu_align.sv
// Combinational lane logic for the LSU.
//   op      : funct3 of the access
//   addr_lo : byte offset within the word
//   st_data : LSB-aligned store data
//   rdata   : raw word returned by the bus
//   wstrb   : byte strobes for a store
//   wdata   : store data shifted onto its byte lanes
//   ld_data : load data extracted and sign/zero-extended
module ysyx_25030093_lsu_align
  import ysyx_25030093_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [4:0]  sh;
  logic [31:0] raw;

  assign sh  = {addr_lo, 3'b000};
  assign raw = rdata >> sh;

  // Stores decode on op[1:0] only: BU/HU store like B/H, and 011/11x
  // fall into the word branch. A halfword at offset 3 loses its upper
  // strobe and byte through the 4-bit / 32-bit truncation.
  always_comb begin
    wstrb = 4'b1111;
    wdata = st_data;
    case (op[1:0])
      2'b00: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = st_data << sh;
      end
      2'b01: begin
        wstrb = 4'b0011 << addr_lo;
        wdata = st_data << sh;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = raw;
    case (op)
      LSU_LB:  ld_data = {{24{raw[7]}}, raw[7:0]};
      LSU_LBU: ld_data = {24'h0, raw[7:0]};
      LSU_LH:  ld_data = {{16{raw[15]}}, raw[15:0]};
      LSU_LHU: ld_data = {16'h0, raw[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: runs one EXU memory request at a time as an AXI-lite
// master transaction (AR/R for loads, AW/W/B for stores) and returns a
// one-cycle resp_valid pulse with extended load data and an error flag.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ysyx_25030093_lsu_if.master (EXU request/response + AXI)
// Build option: define LSU_MISALIGN_TRAP_EN to answer misaligned H/HU/W
// accesses with resp_err=1 without touching the bus.
module ysyx_25030093_lsu
  import ysyx_25030093_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_25030093_lsu_if.master        bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;  // AW handshake already taken
  logic              w_done_q, w_done_d;    // W handshake already taken

  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;

  ysyx_25030093_lsu_align u_align (
    .op      (op_q),
    .addr_lo (addr_q[1:0]),
    .st_data (wdata_q),
    .rdata   (bus.rdata),
    .wstrb   (al_wstrb),
    .wdata   (al_wdata),
    .ld_data (al_ld)
  );

  // NOTE: every output and _d is defaulted first so that no branch leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.arvalid    = 1'b0;
    bus.araddr     = '0;
    bus.rready     = 1'b0;
    bus.awvalid    = 1'b0;
    bus.awaddr     = '0;
    bus.wvalid     = 1'b0;
    bus.wdata      = '0;
    bus.wstrb      = '0;
    bus.bready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d    = bus.req_addr;
          op_d      = bus.req_op;
          wdata_d   = bus.req_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.req_wen ? ST_WR_AW_W : ST_RD_AR;
          if (TrapEn && is_misaligned(bus.req_op, bus.req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RD_AR: begin
        bus.arvalid = 1'b1;
        bus.araddr  = {addr_q[ADDR_W-1:2], 2'b00};
        if (bus.arready) state_d = ST_RD_R;
      end
      ST_RD_R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          rdata_d = al_ld;
          err_d   = bus.rresp != RESP_OKAY;
          state_d = ST_DONE;
        end
      end
      ST_WR_AW_W: begin
        // AW and W complete independently; leave once both have fired,
        // counting a handshake that happens in this very cycle.
        bus.awvalid = !aw_done_q;
        bus.wvalid  = !w_done_q;
        bus.awaddr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.wdata   = al_wdata;
        bus.wstrb   = al_wstrb;
        aw_done_d   = aw_done_q | bus.awready;
        w_done_d    = w_done_q  | bus.wready;
        if (aw_done_d && w_done_d) state_d = ST_WR_B;
      end
      ST_WR_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          err_d   = bus.bresp != RESP_OKAY;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.resp_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      op_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
module tb_ysyx_25030093_lsu;
  import ysyx_25030093_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25030093_lsu_if bus ();
  ysyx_25030093_lsu dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_op = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.rresp = 2'b00;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  32'(bus.req_ready), 32'd1);
    check({tag, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, " resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, " resp_err"},   32'(bus.resp_err), 32'd0);
    check({tag, " arvalid"},    32'(bus.arvalid), 32'd0);
    check({tag, " rready"},     32'(bus.rready), 32'd0);
    check({tag, " awvalid"},    32'(bus.awvalid), 32'd0);
    check({tag, " wvalid"},     32'(bus.wvalid), 32'd0);
    check({tag, " bready"},     32'(bus.bready), 32'd0);
    check({tag, " araddr"},     bus.araddr, 32'd0);
    check({tag, " awaddr"},     bus.awaddr, 32'd0);
    check({tag, " wdata"},      bus.wdata, 32'd0);
    check({tag, " wstrb"},      32'(bus.wstrb), 32'd0);
  endtask

  // Load transaction; slave holds off arready for ar_stall cycles.
  // exp_lat counts cycles from the accepting edge to resp_valid (0 = skip).
  task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] exp_araddr, input logic [31:0] rd,
                          input logic [1:0] rr, input int ar_stall, input bit exp_bus,
                          input logic [31:0] exp_data, input logic exp_err,
                          input int exp_lat, input bit noise);
    int  ar_cnt = 0;
    int  lat = 0;
    bit  done = 1'b0;
    bit  saw_ar = 1'b0;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = 32'h5A5A5A5A;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (noise && cyc == 1) begin
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 32'h80000100;
      end
      bus.arready = 1'b0; bus.rvalid = 1'b0;
      if (bus.arvalid) begin
        saw_ar = 1'b1;
        check({tag, " araddr"}, bus.araddr, exp_araddr);
        bus.arready = (ar_cnt >= ar_stall);
        ar_cnt++;
      end
      if (bus.rready) begin
        bus.rvalid = 1'b1; bus.rdata = rd; bus.rresp = rr;
      end
      if (bus.resp_valid) begin
        done = 1'b1;
        lat  = cyc;
        break;
      end
    end
    check({tag, " resp seen"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, " rdata"}, bus.resp_rdata, exp_data);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
      check({tag, " bus used"}, 32'(saw_ar), 32'(exp_bus));
      if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
      @(negedge clk);
      check({tag, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
      check({tag, " back idle"}, 32'(bus.req_ready), 32'd1);
      if (noise) check({tag, " no queued req"}, 32'(bus.awvalid | bus.arvalid), 32'd0);
    end
  endtask

  // Store transaction; awready/wready offered from cycle aw_at / w_at on.
  task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input int aw_at, input int w_at,
                           input logic [1:0] br, input logic [31:0] exp_awaddr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                           input logic exp_err);
    bit aw_pend = 1'b0, aw_seen = 1'b0, w_pend = 1'b0, w_seen = 1'b0;
    bit first = 1'b1, done = 1'b0;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (aw_pend) aw_seen = 1'b1;
      if (w_pend)  w_seen  = 1'b1;
      aw_pend = 1'b0; w_pend = 1'b0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
      if (first && (bus.awvalid || bus.wvalid)) begin
        first = 1'b0;
        check({tag, " awaddr"}, bus.awaddr, exp_awaddr);
        check({tag, " wdata"}, bus.wdata, exp_wdata);
        check({tag, " wstrb"}, 32'(bus.wstrb), 32'(exp_wstrb));
      end
      if (aw_seen) check({tag, " awvalid dropped"}, 32'(bus.awvalid), 32'd0);
      if (w_seen)  check({tag, " wvalid dropped"}, 32'(bus.wvalid), 32'd0);
      if (!aw_seen && cyc < aw_at) check({tag, " awvalid held"}, 32'(bus.awvalid), 32'd1);
      if (!w_seen && cyc < w_at)   check({tag, " wvalid held"}, 32'(bus.wvalid), 32'd1);
      if (bus.awvalid && cyc >= aw_at) begin bus.awready = 1'b1; aw_pend = 1'b1; end
      if (bus.wvalid && cyc >= w_at)   begin bus.wready = 1'b1;  w_pend = 1'b1;  end
      if (bus.bready) begin
        check({tag, " bready after AW+W"}, 32'(aw_seen && w_seen), 32'd1);
        bus.bvalid = 1'b1; bus.bresp = br;
      end
      if (bus.resp_valid) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, " resp seen"}, 32'(done), 32'd1);
    if (done) begin
      check({tag, " rdata zero"}, bus.resp_rdata, 32'd0);
      check({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
      @(negedge clk);
      check({tag, " resp pulse"}, 32'(bus.resp_valid), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // LB sign-extends byte 3; a stray req_valid mid-flight must be ignored.
    run_load("lb", LSU_LB, 32'h80000003, 32'h80000000, 32'h80FF1234, 2'b00, 0, 1'b1,
             32'hFFFFFF80, 1'b0, 3, 1'b1);
    run_load("lhu", LSU_LHU, 32'h80000002, 32'h80000000, 32'hBEEF0000, 2'b00, 0, 1'b1,
             32'h0000BEEF, 1'b0, 3, 1'b0);
    run_load("lh", LSU_LH, 32'h80000000, 32'h80000000, 32'h00008001, 2'b00, 0, 1'b1,
             32'hFFFF8001, 1'b0, 3, 1'b0);
    run_load("lbu", LSU_LBU, 32'h80000001, 32'h80000000, 32'h0000A500, 2'b00, 0, 1'b1,
             32'h000000A5, 1'b0, 3, 1'b0);

    run_store("sb", LSU_LB, 32'h80000001, 32'h000000AB, 1, 1, 2'b00,
              32'h80000000, 32'h0000AB00, 4'b0010, 1'b0);
    run_store("sh", LSU_LH, 32'h80000002, 32'h00001234, 1, 1, 2'b00,
              32'h80000000, 32'h12340000, 4'b1100, 1'b0);
    run_store("sw split", LSU_LW, 32'h80000004, 32'hCAFEF00D, 1, 4, 2'b00,
              32'h80000004, 32'hCAFEF00D, 4'b1111, 1'b0);
    run_store("sw berr", LSU_LW, 32'h80000008, 32'h01020304, 3, 1, 2'b11,
              32'h80000008, 32'h01020304, 4'b1111, 1'b1);

    // Two arready stall cycles: arrive in DONE at cycle 5, araddr held.
    run_load("lw rerr", LSU_LW, 32'h80000008, 32'h80000008, 32'h11223344, 2'b10, 2, 1'b1,
             32'h11223344, 1'b1, 5, 1'b0);

    // Reset while in RD_R: outputs return to reset values at once.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_op = LSU_LW; bus.req_addr = 32'h80000020;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    check("mid rready", 32'(bus.rready), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid rst");
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    run_load("lw after rst", LSU_LW, 32'h8000000C, 32'h8000000C, 32'hA5A50F0F, 2'b00, 0, 1'b1,
             32'hA5A50F0F, 1'b0, 3, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    run_load("lw trap", LSU_LW, 32'h80000002, 32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 1'b0,
             32'h00000000, 1'b1, 1, 1'b0);
    run_load("lh trap", LSU_LH, 32'h80000001, 32'h80000000, 32'hFFFFFFFF, 2'b00, 0, 1'b0,
             32'h00000000, 1'b1, 1, 1'b0);
`else
    run_store("sh off3", LSU_LH, 32'h80000003, 32'h00001234, 1, 1, 2'b00,
              32'h80000000, 32'h34000000, 4'b1000, 1'b0);
    run_load("lw unaligned", LSU_LW, 32'h80000002, 32'h80000000, 32'hDEADBEEF, 2'b00, 0, 1'b1,
             32'h0000DEAD, 1'b0, 3, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_lsu.md
Name: ysyx_25030093_lsu

Overview:
Load/store unit sitting directly upstream of the SRAM slave. It accepts one memory request at a time from EXU and runs it as an AXI-lite master transaction: AR/R for loads, AW/W/B for stores. It builds byte strobes and write-data lane shifts for stores, and extracts and sign/zero-extends load data before handing it to WBU.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 32; other values unsupported)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  EXU request valid
req_ready  out  1  LSU idle, request accepted when valid&ready
req_wen  in  1  1 = store, 0 = load
req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2), LSB-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data (0 for stores)
resp_err  out  1  bus error or misaligned (feature)
arvalid  out  1  AXI read address valid
araddr  out  32  word-aligned read address
arready  in  1  slave ready
rvalid  in  1  read data valid
rdata  in  32  read data
rresp  in  2  read response
rready  out  1  master ready for R
awvalid  out  1  write address valid
awaddr  out  32  word-aligned write address
awready  in  1  slave ready
wvalid  out  1  write data valid
wdata  out  32  lane-shifted store data
wstrb  out  4  byte strobes
wready  in  1  slave ready
bvalid  in  1  write response valid
bresp  in  2  write response
bready  out  1  master ready for B

Behaviour:
- Reset (async, rst=1): state IDLE; all valid/ready outputs 0 except req_ready=1; resp_rdata=0; resp_err=0; araddr/awaddr/wdata/wstrb=0.
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE: req_ready=1. On req_valid, latch addr/op/wdata/wen and go to RD_AR (load) or WR_AW_W (store). req_ready=0 in all other states.
- RD_AR: arvalid=1, araddr=addr&~3. Held stable until arready. On arready, go to RD_R.
- RD_R: rready=1. On rvalid, latch extracted data and err=(rresp!=0), then go to DONE.
- WR_AW_W: awvalid and wvalid asserted together. Each drops independently once its own ready is seen. Go to WR_B when both handshakes are complete, whether they completed in the same cycle or in different cycles.
- WR_B: bready=1. On bvalid, err=(bresp!=0), then go to DONE.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. Minimum latency from request to resp_valid is 3 cycles when the slave is always ready.
- Load extraction: sh=addr[1:0]*8; raw=rdata>>sh. B: sign-extend raw[7:0]. BU: zero-extend raw[7:0]. H: sign-extend raw[15:0]. HU: zero-extend raw[15:0]. W: raw.
- Store: B gives wstrb=0001<<addr[1:0] and wdata=wdata<<(addr[1:0]*8). H gives wstrb=0011<<addr[1:0]. W gives 1111. Illegal op (011, 11x) is treated as W.
- Halfword at addr[1:0]=3 without the feature: strobe truncated to 1000, upper byte dropped, no error.
- req_valid outside IDLE is ignored and never queued.
- rst mid-transaction aborts immediately to IDLE; the slave is responsible for its own cleanup.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, skips the bus entirely. Goes IDLE→DONE with resp_err=1, resp_rdata=0; no AR/AW is issued.
- Undefined: no alignment check; behaviour exactly as above.

Decomposition:
- Package ysyx_25030093_lsu_pkg: funct3 op localparams (LSU_LB..LSU_LHU), state enum, AXI RESP_OKAY=2'b00.
- Sub-module ysyx_25030093_lsu_align (combinational): inputs op, addr[1:0], store data, rdata. Outputs wstrb, shifted wdata, extended load data. Unit-testable on its own.

Test Plan:
1. LB at 0x80000003 with rdata=0x80FF1234, slave always ready → araddr=0x80000000, resp_rdata=0xFFFFFF80, resp_valid 3 cycles after accept.
2. LHU at 0x80000002 with rdata=0xBEEF0000 → resp_rdata=0x0000BEEF, resp_err=0.
3. SB at 0x80000001, wdata=0x000000AB → awaddr=0x80000000, wstrb=0010, wdata=0x0000AB00; resp_valid after bvalid.
4. SW with awready on cycle 1 and wready on cycle 4 → awvalid drops after cycle 1, wvalid held to cycle 4, bready rises after both handshakes, single resp_valid.
5. LW with rresp=2'b10 and 2 arready stall cycles → araddr held stable; resp_err=1.
6. rst pulse in RD_R → all outputs return to reset values immediately; next LW completes normally. With LSU_MISALIGN_TRAP_EN, LW at 0x80000002 → no arvalid, resp_err=1.
